cisr_result_reorder: RTL
========================

// Module: cisr_result_reorder
// PURPOSE
//  Downstream of the CISR accumulator. Channels finish rows out of order, so (row_id, sum) results arrive out of order.
//  This block buffers them in a window of `depth` rows and emits them strictly in row order 0,1,2,... on a valid/ready stream
//  toward the output-vector writer. It backpressures the accumulator when a result falls outside the window.
// PARAMETERS
//  row_id_size       8   width of row ids; ids wrap modulo 2^row_id_size
//  accumulator_size  32  width of signed result data
//  depth             16  reorder window in rows; power of 2, >= channel_num, < 2^row_id_size
//  depth_log         4   log2(depth)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 async active-low reset
//  start        in   1                 1-cycle pulse: begin new matrix, clears window
//  num_rows     in   row_id_size+1     rows in current matrix; sampled on start
//  res_valid    in   1                 accumulator result valid
//  res_row_id   in   row_id_size       row of result
//  res_data     in   accumulator_size  signed row sum
//  res_ready    out  1                 result accepted when res_valid & res_ready
//  out_valid    out  1                 in-order result valid
//  out_row_id   out  row_id_size       row of output result
//  out_data     out  accumulator_size  signed row sum
//  out_ready    in   1                 consumer accepts when out_valid & out_ready
//  done         out  1                 all num_rows results emitted and accepted
//  err_dup      out  1                 sticky: result hit an already-occupied slot
// BEHAVIOUR
//  - Reset (async, rst_n=0): head=0, rows_left=0, all slot valid bits 0, out_valid=0, out_row_id=0, out_data=0, done=0, err_dup=0.
//    Reset mid-operation discards all buffered results, and no output is produced for them.
//  - start: head<=0, rows_left<=num_rows, valid bits cleared, out_valid<=0, done<=0, err_dup<=0.
//    start has priority over any same-cycle res/out handshake. Those handshakes are ignored.
//  - res_ready is combinational: (res_row_id - head) mod 2^row_id_size < depth, and the block is not in reset.
//    It does not depend on res_valid.
//  - Accept: slot = res_row_id[depth_log-1:0]. If valid[slot]=0: store data and set valid[slot].
//    If valid[slot]=1: drop the write, keep the old data, set err_dup.
//  - Drain: when valid[head slot]=1, rows_left!=0, and the output register is empty or being accepted this cycle:
//    - load out_data/out_row_id=head, out_valid<=1;
//    - clear valid[head slot];
//    - head<=head+1 (wraps), rows_left<=rows_left-1.
//  - Output register holds its values stable while out_valid & ~out_ready.
//    If the drain condition is not met, out_valid falls after acceptance.
//  - Latency: accept of the head row at cycle t -> out_valid at t+2 (slot write at t, drain at t+1).
//    Back-to-back ready rows stream at 1/cycle.
//  - Same slot freed and written in one cycle: impossible by window rule (head+depth not accepted until head advances).
//    Write to a different slot concurrent with drain is allowed.
//  - Results with row_id >= num_rows inside the window are accepted and never emitted. Each is cleared by the next start.
//  - done<=1 when rows_left==0 and out_valid==0 (after start). num_rows=0 -> done one cycle after start.
//  - All window arithmetic is modulo 2^row_id_size, so row ids may wrap within a matrix.
// STRUCTURE
//  - params.vh: channel_num, reorder depth/depth_log defaults, row_id_size, accumulator_size shared with cisr_acc.
//  - One sub-module, cisr_reorder_ram: depth x accumulator_size storage.
//    It has 1 write port and 1 async read port, addressed by slot.
//  - Valid bits, head/rows_left counters, and the output register stay in the top level.
// TESTING
//  - In order: num_rows=4, results rows 0..3 data 10,20,30,40, out_ready=1 -> out rows 0..3 same data, first out 2 cycles after row 0, done after row 3.
//  - Reversed: rows 3,2,1,0 (data -3,-2,-1,-5) -> nothing out until row 0 arrives, then 0,1,2,3 on 4 consecutive cycles, signed data intact.
//  - Window full: depth=16, head=0, present row 16 -> res_ready=0 until row 0 drains, then accepted, emitted 17th.
//  - Backpressure: out_ready=0 for 5 cycles with rows 0,1 buffered -> out row 0 held stable, no loss, then 0,1 in order.
//  - Duplicate: row 2 written twice (7 then 9) -> err_dup=1, row 2 emitted with 7.
//  - Wrap/reset: num_rows=300, random order inside window -> ids 0..255,0..43 in order, done.
//    Then rst_n low mid-stream -> out_valid=0, done=0 immediately.

Source files
------------

// File: rtl/cisr_result_reorder_pkg.sv
// Shared sizing defaults for the CISR result reorder buffer.
// These values must match the ones used by the upstream accumulator.
package cisr_result_reorder_pkg;

    localparam int unsigned DEF_CHANNEL_NUM      = 8;
    localparam int unsigned DEF_ROW_ID_SIZE      = 8;
    localparam int unsigned DEF_ACCUMULATOR_SIZE = 32;
    localparam int unsigned DEF_DEPTH            = 16;
    localparam int unsigned DEF_DEPTH_LOG        = 4;

endpackage

// File: rtl/cisr_reorder_ram.sv
// Slot-addressed result storage for the reorder window.
// It has one synchronous write port and one asynchronous read port.
module cisr_reorder_ram #(
    parameter int unsigned depth     = 16,
    parameter int unsigned depth_log = 4,
    parameter int unsigned width     = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [depth_log-1:0] waddr,
    input  logic [width-1:0]     wdata,
    input  logic [depth_log-1:0] raddr,
    output logic [width-1:0]     rdata_c
);

    logic [width-1:0] mem [depth];

    // Storage needs no reset: slot valid bits in the parent gate every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/cisr_result_reorder.sv
// Reorders out-of-order (row_id, sum) results from the CISR accumulator.
// Results are emitted strictly in row order on a valid/ready stream.
module cisr_result_reorder
    import cisr_result_reorder_pkg::*;
#(
    parameter int unsigned row_id_size      = DEF_ROW_ID_SIZE,
    parameter int unsigned accumulator_size = DEF_ACCUMULATOR_SIZE,
    parameter int unsigned depth            = DEF_DEPTH,
    parameter int unsigned depth_log        = DEF_DEPTH_LOG
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [row_id_size:0]        num_rows,
    input  logic                        res_valid,
    input  logic [row_id_size-1:0]      res_row_id,
    input  logic [accumulator_size-1:0] res_data,
    output logic                        res_ready,
    output logic                        out_valid,
    output logic [row_id_size-1:0]      out_row_id,
    output logic [accumulator_size-1:0] out_data,
    input  logic                        out_ready,
    output logic                        done,
    output logic                        err_dup
);

    logic [row_id_size-1:0]      head;
    logic [row_id_size-1:0]      win_off;
    logic [row_id_size:0]        rows_left;
    logic [depth-1:0]            slot_valid;
    logic [depth-1:0]            slot_valid_nxt;
    logic                        armed;
    logic [depth_log-1:0]        wr_slot;
    logic [depth_log-1:0]        head_slot;
    logic                        res_fire;
    logic                        wr_en;
    logic                        dup_hit;
    logic                        drain;
    logic [accumulator_size-1:0] rd_data;

    // Window check is modulo 2^row_id_size so ids may wrap inside one matrix.
    assign win_off   = res_row_id - head;
    assign res_ready = rst_n & (win_off < row_id_size'(depth));

    assign wr_slot   = res_row_id[depth_log-1:0];
    assign head_slot = head[depth_log-1:0];
    assign res_fire  = res_valid & res_ready & ~start;
    assign wr_en     = res_fire & ~slot_valid[wr_slot];
    assign dup_hit   = res_fire & slot_valid[wr_slot];
    assign drain     = ~start & slot_valid[head_slot] & (rows_left != '0)
                     & (~out_valid | out_ready);

    // The window rule guarantees the drained slot and the written slot differ.
    always_comb begin
        slot_valid_nxt = slot_valid;
        if (drain) begin
            slot_valid_nxt[head_slot] = 1'b0;
        end
        if (wr_en) begin
            slot_valid_nxt[wr_slot] = 1'b1;
        end
    end

    cisr_reorder_ram #(
        .depth     (depth),
        .depth_log (depth_log),
        .width     (accumulator_size)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (wr_slot),
        .wdata   (res_data),
        .raddr   (head_slot),
        .rdata_c (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            rows_left  <= '0;
            slot_valid <= '0;
            armed      <= 1'b0;
            out_valid  <= 1'b0;
            out_row_id <= '0;
            out_data   <= '0;
            done       <= 1'b0;
            err_dup    <= 1'b0;
        end else if (start) begin
            head       <= '0;
            rows_left  <= num_rows;
            slot_valid <= '0;
            armed      <= 1'b1;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            err_dup    <= 1'b0;
        end else begin
            slot_valid <= slot_valid_nxt;
            if (dup_hit) begin
                err_dup <= 1'b1;
            end
            if (drain) begin
                out_valid  <= 1'b1;
                out_row_id <= head;
                out_data   <= rd_data;
                head       <= head + row_id_size'(1);
                rows_left  <= rows_left - (row_id_size + 1)'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            done <= armed & (rows_left == '0) & ~out_valid;
        end
    end

endmodule
